blowfish_feistel_engine: RTL

BLOWFISH_FEISTEL_ENGINE -- requirements
Module: blowfish_feistel_engine

---
 rtl/blowfish_pkg.sv | 25 ++
 rtl/blowfish_skey_sel.sv | 17 +
 rtl/blowfish_feistel_engine.sv | 108 ++++++++++
 3 files changed

// File: rtl/blowfish_pkg.sv
// Shared types and helpers for the Blowfish-style Feistel engine:
// FSM state encoding, subkey lookup phases and the subkey index rule.
`timescale 1ns/1ps
package blowfish_pkg;
  localparam int DEF_BLOCK_W = 128;
  localparam int DEF_ROUNDS  = 16;

  typedef enum logic [2:0] {S_IDLE, S_ROUND, S_FWAIT, S_FINAL, S_DONE} state_t;

  // Which subkey the datapath consumes in the current cycle.
  typedef enum logic [1:0] {PH_ROUND, PH_FWAIT, PH_FINAL} phase_t;

  // FWAIT fetches the subkey folded into the new L of the last round; FINAL
  // fetches the one folded into the output upper half.
  function automatic int subkey_index(input int counter, input logic encrypt,
                                      input phase_t phase, input int nk);
    int idx;
    case (phase)
      PH_ROUND: idx = encrypt ? counter : nk - 1 - counter;
      PH_FWAIT: idx = encrypt ? nk - 2 : 1;
      default:  idx = encrypt ? nk - 1 : 0;
    endcase
    return idx;
  endfunction
endpackage

// File: rtl/blowfish_skey_sel.sv
// Maps round counter, mode and lookup phase to the subkey array index.
`timescale 1ns/1ps
module blowfish_skey_sel
  import blowfish_pkg::*;
#(
  parameter int NK = 18,
  parameter int CW = $clog2(NK)
) (
  input  logic [CW-1:0] i_counter,
  input  logic          i_encrypt,
  input  phase_t        i_phase,
  output logic [CW-1:0] o_skey_idx
);
  always_comb begin
    o_skey_idx = CW'(subkey_index(int'(i_counter), i_encrypt, i_phase, NK));
  end
endmodule

// File: rtl/blowfish_feistel_engine.sv
// Iterative Blowfish Feistel core: one subkey XOR cycle plus one external
// F-function handshake per round, then a single output whitening cycle.
`timescale 1ns/1ps
module blowfish_feistel_engine
  import blowfish_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int ROUNDS  = DEF_ROUNDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_encrypt,
  input  logic [BLOCK_W-1:0]          in_data,
  input  logic                        skey_ready,
  output logic [$clog2(ROUNDS+2)-1:0] skey_idx,
  input  logic [BLOCK_W/2-1:0]        skey_data,
  output logic                        f_req,
  output logic [BLOCK_W/2-1:0]        f_x,
  input  logic                        f_ack,
  input  logic [BLOCK_W/2-1:0]        f_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BLOCK_W-1:0]          out_data,
  output logic                        busy
);
  localparam int H  = BLOCK_W / 2;
  localparam int NK = ROUNDS + 2;
  localparam int CW = $clog2(NK);

  state_t          r_state, w_state_next;
  logic [H-1:0]    r_l, r_r;
  logic            r_enc;
  logic [CW-1:0]   r_cnt;
  logic [BLOCK_W-1:0] r_out;
  logic            w_in_fire;
  logic            w_last;
  phase_t          w_phase;

  assign in_ready  = (r_state == S_IDLE) && skey_ready;
  assign w_in_fire = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(ROUNDS - 1));
  assign f_req     = (r_state == S_FWAIT);
  assign f_x       = (r_state == S_FWAIT) ? r_l : '0;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_phase = PH_ROUND;
    if (r_state == S_FWAIT)      w_phase = PH_FWAIT;
    else if (r_state == S_FINAL) w_phase = PH_FINAL;
  end

  blowfish_skey_sel #(.NK(NK), .CW(CW)) u_skey_sel (
    .i_counter  (r_cnt),
    .i_encrypt  (r_enc),
    .i_phase    (w_phase),
    .o_skey_idx (skey_idx)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_fire) w_state_next = S_ROUND;
      S_ROUND: w_state_next = S_FWAIT;
      S_FWAIT: if (f_ack) w_state_next = w_last ? S_FINAL : S_ROUND;
      S_FINAL: w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_l     <= '0;
      r_r     <= '0;
      r_enc   <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            r_l   <= in_data[BLOCK_W-1:H];
            r_r   <= in_data[H-1:0];
            r_enc <= in_encrypt;
            r_cnt <= '0;
          end
        end
        S_ROUND: r_l <= r_l ^ skey_data;
        S_FWAIT: begin
          // Last round also folds in the lower-half output whitening subkey.
          if (f_ack) begin
            r_r   <= r_l;
            r_l   <= r_r ^ f_y ^ (w_last ? skey_data : '0);
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FINAL: r_out <= {r_r ^ skey_data, r_l};
        default: ;
      endcase
    end
  end
endmodule
